// File: rtl/branch_resolve_unit.sv
// Branch resolution and prediction unit.
//  - IF side: BHT of 2-bit saturating counters plus a direct-mapped jalr BTB, looked up
//    combinationally from the current array state.
//  - EX side: resolves conditional branches and jalr against the prediction carried down
//    the pipe, raises a registered one-cycle PL_flush with the redirect PC, and trains
//    the predictor tables.
// Optional feature: define BRU_PERF_CNT_EN to add perf_branches / perf_mispred counters.

module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned BTB_DEPTH = 16,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  // IF-side lookup
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  // EX-side resolution
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            B_type,
  input  logic [2:0]      br_op,
  input  logic            jalr,
  input  logic            zero,
  input  logic            slt_result,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_pc_new,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            PL_flush,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
`endif
);

  localparam int unsigned BhtIdxW = $clog2(BHT_DEPTH);
  localparam int unsigned BtbIdxW = $clog2(BTB_DEPTH);
  localparam int unsigned TagW    = XLEN - BtbIdxW - 2;

  // funct3 encodings of the conditional branches
  localparam logic [2:0] OpBeq  = 3'b000;
  localparam logic [2:0] OpBne  = 3'b001;
  localparam logic [2:0] OpBlt  = 3'b100;
  localparam logic [2:0] OpBge  = 3'b101;
  localparam logic [2:0] OpBltu = 3'b110;
  localparam logic [2:0] OpBgeu = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      bht_q        [BHT_DEPTH];
  logic            btb_valid_q  [BTB_DEPTH];
  logic [TagW-1:0] btb_tag_q    [BTB_DEPTH];
  logic [XLEN-1:0] btb_target_q [BTB_DEPTH];

  logic            flush_q;
  logic            flush_d;
  logic [XLEN-1:0] redirect_q;
  logic [XLEN-1:0] redirect_d;

  // ---------------------------------------------------------------------------
  // IF-side lookup
  // ---------------------------------------------------------------------------
  logic [BhtIdxW-1:0] if_bht_idx;
  logic [BtbIdxW-1:0] if_btb_idx;
  logic [TagW-1:0]    if_btb_tag;
  logic               if_btb_hit;

  assign if_bht_idx = if_pc[BhtIdxW+1:2];
  assign if_btb_idx = if_pc[BtbIdxW+1:2];
  assign if_btb_tag = if_pc[XLEN-1:BtbIdxW+2];

  // Lookup reads the registered arrays only; a same-cycle update is not forwarded.
  always_comb begin
    if_btb_hit     = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_btb_tag);
    if_pred_taken  = bht_q[if_bht_idx][1];
    if_pred_target = if_btb_hit ? btb_target_q[if_btb_idx] : (if_pc + XLEN'(4));
  end

  // ---------------------------------------------------------------------------
  // EX-side resolution
  // ---------------------------------------------------------------------------
  logic               res;
  logic               is_branch;
  logic               taken;
  logic               mispredict_b;
  logic               mispredict_j;
  logic [XLEN-1:0]    jalr_target;
  logic [XLEN-1:0]    ex_pc_plus4;
  logic [BhtIdxW-1:0] ex_bht_idx;
  logic [BtbIdxW-1:0] ex_btb_idx;
  logic [TagW-1:0]    ex_btb_tag;

  // The instruction sitting in EX during a flush cycle is wrong-path and is ignored.
  assign res         = ex_valid & ~flush_q;
  // jalr takes precedence over a simultaneously asserted B_type.
  assign is_branch   = B_type & ~jalr;
  assign jalr_target = {jalr_pc_new[XLEN-1:1], 1'b0};
  assign ex_pc_plus4 = ex_pc + XLEN'(4);
  assign ex_bht_idx  = ex_pc[BhtIdxW+1:2];
  assign ex_btb_idx  = ex_pc[BtbIdxW+1:2];
  assign ex_btb_tag  = ex_pc[XLEN-1:BtbIdxW+2];

  // Branch condition decode from funct3 and the ALU flags.
  always_comb begin
    taken = 1'b0;
    case (br_op)
      OpBeq:          taken = zero;
      OpBne:          taken = ~zero;
      OpBlt, OpBltu:  taken = slt_result;
      OpBge, OpBgeu:  taken = ~slt_result;
      default:        taken = 1'b0;
    endcase
  end

  // Mispredict detection and next flush / redirect values.
  always_comb begin
    mispredict_b = res & is_branch & (taken ^ ex_pred_taken);
    mispredict_j = res & jalr & (jalr_target != ex_pred_target);
    flush_d      = mispredict_b | mispredict_j;
    redirect_d   = redirect_q;
    if (flush_d) begin
      if (jalr) begin
        redirect_d = jalr_target;
      end else if (taken) begin
        redirect_d = br_target;
      end else begin
        redirect_d = ex_pc_plus4;
      end
    end
  end

  // Registered flush pulse and redirect PC; redirect holds between flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign PL_flush    = flush_q;
  assign redirect_pc = redirect_q;

  // ---------------------------------------------------------------------------
  // Predictor training
  // ---------------------------------------------------------------------------
  // BHT: saturating up on taken, saturating down on not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (res && is_branch) begin
      if (taken) begin
        if (bht_q[ex_bht_idx] != 2'b11) begin
          bht_q[ex_bht_idx] <= bht_q[ex_bht_idx] + 2'b01;
        end
      end else begin
        if (bht_q[ex_bht_idx] != 2'b00) begin
          bht_q[ex_bht_idx] <= bht_q[ex_bht_idx] - 2'b01;
        end
      end
    end
  end

  // BTB: every resolved jalr writes its entry, replacing whatever was there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else if (res && jalr) begin
      btb_valid_q[ex_btb_idx]  <= 1'b1;
      btb_tag_q[ex_btb_idx]    <= ex_btb_tag;
      btb_target_q[ex_btb_idx] <= jalr_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_mispred_q;

  // Count resolved control-flow instructions and mispredicts; both wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      if (res && (B_type || jalr)) begin
        perf_branches_q <= perf_branches_q + 32'd1;
      end
      if (flush_d) begin
        perf_mispred_q <= perf_mispred_q + 32'd1;
      end
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispred  = perf_mispred_q;
`else
  // Counters not built.
`endif

  // Byte-offset bits of if_pc and bit 0 of the jalr target carry no information here.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], jalr_pc_new[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default parameters).
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            B_type;
  logic [2:0]      br_op;
  logic            jalr;
  logic            zero;
  logic            slt_result;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_pc_new;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            PL_flush;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispred;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .B_type         (B_type),
    .br_op          (br_op),
    .jalr           (jalr),
    .zero           (zero),
    .slt_result     (slt_result),
    .br_target      (br_target),
    .jalr_pc_new    (jalr_pc_new),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .PL_flush       (PL_flush),
    .redirect_pc    (redirect_pc)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    B_type         = 1'b0;
    jalr           = 1'b0;
    br_op          = 3'b000;
    zero           = 1'b0;
    slt_result     = 1'b0;
    ex_pc          = '0;
    br_target      = '0;
    jalr_pc_new    = '0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [2:0] op, input logic z,
                          input logic slt, input logic [31:0] tgt, input logic pred);
    idle();
    ex_valid      = 1'b1;
    B_type        = 1'b1;
    ex_pc         = pc;
    br_op         = op;
    zero          = z;
    slt_result    = slt;
    br_target     = tgt;
    ex_pred_taken = pred;
  endtask

  task automatic drive_jalr(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic [31:0] pred_tgt, input logic also_b);
    idle();
    ex_valid       = 1'b1;
    jalr           = 1'b1;
    ex_pc          = pc;
    jalr_pc_new    = tgt;
    ex_pred_target = pred_tgt;
    // Optional simultaneous B_type: a taken, predicted-not-taken beq that must be ignored.
    B_type         = also_b;
    zero           = also_b;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, 64'(if_pred_taken), 64'(exp_taken));
    check({tag, "_target"}, 64'(if_pred_target), 64'(exp_tgt));
  endtask

  task automatic expect_flush(input string tag, input logic f, input logic [31:0] rpc);
    check({tag, "_flush"}, 64'(PL_flush), 64'(f));
    check({tag, "_redirect"}, 64'(redirect_pc), 64'(rpc));
  endtask

  initial begin
    rst   = 1'b1;
    if_pc = '0;
    idle();
    tick();
    // Reset state
    expect_flush("reset", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    look("rst_lu_100", 32'h100, 1'b0, 32'h104);
    look("rst_lu_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Taken beq predicted not-taken: flush to br_target, counter 01->10
    drive_br(32'h100, 3'b000, 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    expect_flush("beq_mis", 1'b1, 32'h200);
    idle();
    look("beq_ctr10", 32'h100, 1'b1, 32'h104);
    tick();
    expect_flush("beq_pulse", 1'b0, 32'h200);

    // Two correctly predicted taken beq: counter 10->11->11, no flush
    drive_br(32'h100, 3'b000, 1'b1, 1'b0, 32'h200, 1'b1);
    tick();
    check("beq_ok1_flush", 64'(PL_flush), 64'd0);
    tick();
    check("beq_ok2_flush", 64'(PL_flush), 64'd0);
    // Not-taken beq predicted taken: flush to pc+4, counter 11->10 (still taken)
    drive_br(32'h100, 3'b000, 1'b0, 1'b0, 32'h200, 1'b1);
    tick();
    expect_flush("beq_nt1", 1'b1, 32'h104);
    idle();
    look("sat_ctr10", 32'h100, 1'b1, 32'h104);
    tick();
    drive_br(32'h100, 3'b000, 1'b0, 1'b0, 32'h200, 1'b1);
    tick();
    expect_flush("beq_nt2", 1'b1, 32'h104);
    idle();
    look("ctr01", 32'h100, 1'b0, 32'h104);
    tick();

    // blt taken (slt=1) predicted not-taken
    drive_br(32'h104, 3'b100, 1'b0, 1'b1, 32'h80, 1'b0);
    tick();
    expect_flush("blt_mis", 1'b1, 32'h80);
    idle();
    tick();
    // bgeu not taken (slt=1) predicted taken
    drive_br(32'h108, 3'b111, 1'b0, 1'b1, 32'h900, 1'b1);
    tick();
    expect_flush("bgeu_mis", 1'b1, 32'h10C);
    idle();
    tick();
    // Undefined funct3 is never taken; predicted not-taken -> no flush
    drive_br(32'h10C, 3'b010, 1'b1, 1'b1, 32'hA00, 1'b0);
    tick();
    expect_flush("op010", 1'b0, 32'h10C);
    // bne not taken at top of address space: pc+4 wraps to 0
    drive_br(32'hFFFF_FFFC, 3'b001, 1'b1, 1'b0, 32'h400, 1'b1);
    tick();
    expect_flush("bne_wrap", 1'b1, 32'h0);
    idle();
    tick();

    // jalr mispredict: bit 0 cleared, BTB trained
    drive_jalr(32'h40, 32'h1235, 32'h44, 1'b0);
    tick();
    expect_flush("jalr_mis", 1'b1, 32'h1234);
    idle();
    look("btb_hit40", 32'h40, 1'b0, 32'h1234);
    look("btb_tagmiss", 32'h80, 1'b0, 32'h84);
    tick();
    // jalr correctly predicted
    drive_jalr(32'h40, 32'h1234, 32'h1234, 1'b0);
    tick();
    expect_flush("jalr_ok", 1'b0, 32'h1234);
    // jalr with B_type also high: B ignored, BTB entry 0 overwritten with tag of 0x100
    drive_jalr(32'h100, 32'h301, 32'h300, 1'b1);
    tick();
    expect_flush("jalr_b", 1'b0, 32'h1234);
    idle();
    look("jalr_b_nobht", 32'h100, 1'b0, 32'h300);
    look("btb_evict40", 32'h40, 1'b0, 32'h44);

    // Mispredict followed by a would-be mispredict during the flush cycle
    drive_br(32'h100, 3'b000, 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    expect_flush("shadow_first", 1'b1, 32'h200);
    drive_br(32'h180, 3'b000, 1'b1, 1'b0, 32'h500, 1'b0);
    tick();
    expect_flush("shadow_second", 1'b0, 32'h200);
    idle();
    look("shadow_nobht", 32'h180, 1'b0, 32'h184);
    look("pre_rst_100", 32'h100, 1'b1, 32'h300);

    // Reset while flush is pending
    drive_br(32'h180, 3'b000, 1'b1, 1'b0, 32'h600, 1'b0);
    tick();
    expect_flush("pend", 1'b1, 32'h600);
`ifdef BRU_PERF_CNT_EN
    check("perf_br_pre", 64'(perf_branches), 64'd14);
    check("perf_mis_pre", 64'(perf_mispred), 64'd9);
`endif
    idle();
    rst = 1'b1;
    #1;
    expect_flush("mid_rst", 1'b0, 32'h0);
    look("mid_rst_bht", 32'h100, 1'b0, 32'h104);
`ifdef BRU_PERF_CNT_EN
    check("perf_br_rst", 64'(perf_branches), 64'd0);
    check("perf_mis_rst", 64'(perf_mispred), 64'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    expect_flush("post_rst", 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
